// File: rtl/lc_mux_arb.sv
// rtl/lc_mux_arb.sv - N-channel valid/ready mux with ctrl-selected or round-robin burst grants
//
// Ports:
//   c          clock, rising edge
//   rst_n      asynchronous active-low reset
//   ctrl       channel select, sampled in IDLE when MODE=0
//   in_data    channel k payload at [k*DATA_W +: DATA_W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered payload to target
//   out_valid  registered valid to target
//   out_ready  target ready
//   err_in     target error for the beat in the output register
//   err_out    err_in routed back to the beat's source channel, one cycle later
//   grant      currently granted channel index
//   busy       high while a burst grant is held
//   sel_err    pulse for an out-of-range ctrl seen in IDLE

module lc_mux_arb #(
   parameter int DATA_W    = 1,
   parameter int N_CHAN    = 2,
   parameter int CTRL_W    = 2,
   parameter int MODE      = 0,
   parameter int BURST_LEN = 1
) (
   input  logic                     c,
   input  logic                     rst_n,
   input  logic [CTRL_W-1:0]        ctrl,
   input  logic [N_CHAN*DATA_W-1:0] in_data,
   input  logic [N_CHAN-1:0]        in_valid,
   output logic [N_CHAN-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     err_in,
   output logic [N_CHAN-1:0]        err_out,
   output logic [CTRL_W-1:0]        grant,
   output logic                     busy,
   output logic                     sel_err
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int N_SEL = 1 << CTRL_W;
   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   state_t              state_q, state_d;
   logic [CTRL_W-1:0]   grant_d;
   logic [CTRL_W-1:0]   rr_ptr;
   logic [CTRL_W-1:0]   rr_pick;
   logic [CTRL_W-1:0]   rr_next;
   logic [CTRL_W-1:0]   src_q;
   logic [7:0]          beat_cnt;
   logic [N_SEL-1:0]    valid_ext;
   logic [2*N_CHAN-1:0] valid_rot;
   logic                rr_found;
   logic                ctrl_ok;
   logic                sel_err_d;
   logic                grant_valid;
   logic [DATA_W-1:0]   grant_data;
   logic                can_accept;
   logic                accept;
   logic                last_beat;
   logic [N_CHAN-1:0]   err_d;

   assign busy       = (state_q == GRANT);
   assign can_accept = !out_valid || out_ready;
   assign accept     = busy && grant_valid && can_accept;
   assign last_beat  = (beat_cnt == LAST_BEAT);
   assign ctrl_ok    = int'(ctrl) < N_CHAN;
   assign rr_next    = (int'(grant) == N_CHAN - 1) ? '0 : grant + CTRL_W'(1);

   // valid widened to the full ctrl range so an out-of-range ctrl can index it safely
   always_comb begin
      valid_ext = '0;
      valid_ext[N_CHAN-1:0] = in_valid;
   end

   // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the next round-robin winner
   always_comb begin
      valid_rot = {in_valid, in_valid} >> rr_ptr;
      rr_found  = 1'b0;
      rr_pick   = '0;
      for (int i = N_CHAN - 1; i >= 0; i--) begin
         if (valid_rot[i]) begin
            rr_found = 1'b1;
            rr_pick  = CTRL_W'((int'(rr_ptr) + i) % N_CHAN);
         end
      end
   end

   always_comb begin
      grant_data  = '0;
      grant_valid = 1'b0;
      in_ready    = '0;
      err_d       = '0;
      for (int k = 0; k < N_CHAN; k++) begin
         if (grant == CTRL_W'(k)) begin
            grant_data  = in_data[k*DATA_W +: DATA_W];
            grant_valid = in_valid[k];
            in_ready[k] = busy && can_accept;
         end
         if (src_q == CTRL_W'(k)) begin
            err_d[k] = out_valid && err_in;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant;
      sel_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (MODE == 0) begin
               if (!ctrl_ok) begin
                  sel_err_d = 1'b1;
               end else if (valid_ext[ctrl]) begin
                  grant_d = ctrl;
                  state_d = GRANT;
               end
            end else if (rr_found) begin
               grant_d = rr_pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // Grant is locked until the final beat of the burst is accepted
            if (accept && last_beat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant   <= '0;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         rr_ptr    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         src_q     <= '0;
         err_out   <= '0;
         sel_err   <= 1'b0;
      end else begin
         sel_err <= sel_err_d;
         err_out <= err_d;
         if (accept) begin
            out_data  <= grant_data;
            out_valid <= 1'b1;
            src_q     <= grant;
            if (last_beat) begin
               beat_cnt <= '0;
               rr_ptr   <= rr_next;
            end else begin
               beat_cnt <= beat_cnt + 8'd1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/lc_mux_arb.md
Name: lc_mux_arb

Overview:
- Parametrised successor to the generated 2-channel control-selected channel mux.
- Merges N_CHAN initiator channels of DATA_W bits onto one target channel, using valid/ready handshakes and a registered output.
- Channel selection is either driven by the initiator's ctrl word (MODE=0) or done by internal round-robin arbitration (MODE=1).
- Holds each grant for a burst of BURST_LEN beats, and routes the target's err back to the channel that sent the data.

Parameters:
- DATA_W, 1, width of each channel payload (packed union width).
- N_CHAN, 2, number of input channels (2..16).
- CTRL_W, 2, ctrl/grant width; CTRL_W >= clog2(N_CHAN).
- MODE, 0, 0 = ctrl-selected, 1 = round-robin.
- BURST_LEN, 1, beats per grant (1..255).

Ports:
- c  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low; deassertion synchronous to c.
- ctrl  in  CTRL_W  channel select, sampled only in IDLE (MODE=0); ignored in MODE=1.
- in_data  in  N_CHAN*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  N_CHAN  per-channel valid.
- in_ready  out  N_CHAN  per-channel ready; one-hot or zero.
- out_data  out  DATA_W  registered payload to target.
- out_valid  out  1  registered valid to target.
- out_ready  in  1  target ready.
- err_in  in  1  target error.
- err_out  out  N_CHAN  error routed to source channel; one-hot or zero.
- grant  out  CTRL_W  currently granted channel index.
- busy  out  1  high in GRANT state.
- sel_err  out  1  one-cycle pulse on an out-of-range ctrl.

Behaviour:
- Reset values:
  - state = IDLE; grant = 0; beat_cnt = 0; rr_ptr = 0.
  - out_valid = 0; out_data = 0.
  - in_ready = 0; err_out = 0; busy = 0; sel_err = 0.
- FSM, IDLE state:
  - MODE=0: if ctrl < N_CHAN and in_valid[ctrl] = 1, latch grant = ctrl and go to GRANT next cycle.
  - MODE=0: if ctrl >= N_CHAN, pulse sel_err for 1 cycle and stay in IDLE. The pulse repeats every cycle while the condition holds.
  - MODE=1: grant the first channel with valid set, searching from rr_ptr upward with wrap modulo N_CHAN; go to GRANT next cycle.
  - No candidate: stay in IDLE.
- FSM, GRANT state:
  - in_ready[grant] = (!out_valid | out_ready); all other in_ready bits are 0.
  - Beat accepted when in_valid[grant] & in_ready[grant].
  - On each accepted beat: out_data <= in_data[grant]; out_valid <= 1; beat_cnt increments.
  - When an accepted beat has beat_cnt == BURST_LEN-1: beat_cnt <= 0, go to IDLE, and rr_ptr <= (grant+1) mod N_CHAN.
  - Lock: if in_valid[grant] drops mid-burst, stay in GRANT and wait. No other channel may be granted until the burst completes.
- Output register:
  - out_valid clears when out_ready = 1 and no new beat is accepted in the same cycle.
  - out_data and out_valid are held stable while out_valid = 1 and out_ready = 0.
  - Accept and drain in the same cycle gives full throughput: 1 beat/cycle in steady state.
- Latency:
  - Arbitration: 1 cycle (IDLE to GRANT); no beat is accepted in IDLE.
  - Data: a beat accepted in cycle t is on out_data/out_valid in cycle t+1.
  - Minimum burst period: BURST_LEN+1 cycles.
- Error routing:
  - src_q records the channel index of the beat currently in the output register.
  - err_out[src_q] <= err_in, registered with 1-cycle latency.
  - err_out = 0 while out_valid was 0 in the previous cycle.
- Simultaneous events:
  - Last beat of a burst and a new request arriving together: re-arbitration happens in the following IDLE cycle.
  - In MODE=1 the just-finished channel has lowest priority.
- Reset mid-burst: all state clears immediately and asynchronously; any in-flight output beat is dropped.
- ctrl changing during GRANT has no effect.

Test Plan:
- MODE=0, N_CHAN=2, BURST_LEN=1: ctrl=1, in_valid=2'b11, in_data={1,0}, out_ready=1.
  - in_ready=2'b10 one cycle after ctrl is sampled.
  - out_data=1, out_valid=1 the following cycle; grant=1.
- MODE=0, ctrl=3 with N_CHAN=2: sel_err pulses every cycle while held, no in_ready asserted, busy=0. Then ctrl=0 -> channel 0 is granted.
- MODE=1, N_CHAN=4, all in_valid=1, BURST_LEN=2, out_ready=1:
  - grant sequence 0,1,2,3,0.
  - Each channel gets exactly 2 beats, with a 1-cycle IDLE gap between grants.
- Backpressure: out_ready=0 for 3 cycles after the first beat.
  - out_data held, in_ready[grant]=0.
  - After out_ready=1, beats resume with none lost or duplicated (scoreboard check).
- Lock and err routing:
  - Channel 2 is granted, drops in_valid mid-burst while channel 1 is valid: grant stays 2 until the burst completes.
  - err_in=1 while a channel-2 beat is in the output register -> err_out=4'b0100 one cycle later.
- Reset: assert rst_n=0 mid-burst, asynchronously (off the clock edge).
  - out_valid, in_ready, busy and err_out go to 0 immediately.
  - After release, MODE=1 arbitration restarts from channel 0.
